uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter BUSY_TO, default 1023: maximum clk cycles to wait for tx_ready to fall after tx_start.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  N_REQ  per-requester byte valid.
REQ-006 req_data  in  8*N_REQ  per-requester byte; slice i is bits [8i+7:8i].
REQ-007 req_last  in  N_REQ  marks the final byte of requester i's packet.
REQ-008 req_ack  out  N_REQ  one-cycle pulse; requester i's byte has been accepted.
REQ-009 tx_data  out  8  byte to transmitter.
REQ-010 tx_start  out  1  one-cycle start pulse to transmitter.
REQ-011 tx_ready  in  1  transmitter idle flag.
REQ-012 grant  out  N_REQ  one-hot owner of the link; all-zero when no owner.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 timeout_err  out  1  sticky; set on a BUSY_TO expiry.
REQ-015 timeout_clr  in  1  clears timeout_err.

Function
REQ-016 FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: when tx_ready=1 and any req_valid=1, select a winner by round-robin and go to LOAD.
  - Search starts at index (last_owner+1) mod N_REQ and takes the first valid requester.
  - grant is set to the winner's one-hot code.
REQ-018 LOAD: latch req_data of the granted requester into tx_data, pulse req_ack for exactly one cycle, record the req_last value, then go to START.
REQ-019 START: assert tx_start for exactly one cycle, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: when tx_ready=0, go to WAIT_DONE.
  - If tx_ready stays 1 for BUSY_TO cycles, set timeout_err and go to WAIT_DONE.
REQ-021 WAIT_DONE: when tx_ready=1, the packet continues or ends.
  - If the recorded last=0 and the owner's req_valid=1, go to LOAD with the same grant (packet lock).
  - If the recorded last=1, clear grant, update last_owner, and go to IDLE.
  - If the recorded last=0 and the owner's req_valid=0, remain in WAIT_DONE holding grant until req_valid rises; other requesters are not served.
REQ-022 Latency from IDLE with req_valid and tx_ready both high to tx_start is 2 cycles: LOAD, then START.
REQ-023 Inter-byte gap: the second and later bytes of a packet take tx_start 2 cycles after tx_ready rises.
REQ-024 tx_data holds stable from LOAD until the next LOAD.
REQ-025 req_ack fires only in LOAD, only to the granted index, and at most one bit at a time.
REQ-026 Requesters hold req_data and req_last stable while req_valid=1 and ack has not been received; the block does not check this.
REQ-027 Round-robin wrap: last_owner=N_REQ-1 makes the search start at index 0.
  - last_owner resets to N_REQ-1, so index 0 wins first after reset.
REQ-028 A req_valid deassert of a non-owner during arbitration or transmission has no effect.
REQ-029 A timeout_clr and a timeout expiry in the same cycle leave timeout_err set (set wins).

Reset
REQ-030 Asserting reset at any time, including mid-packet, forces state to IDLE and clears these outputs: grant=0, req_ack=0, tx_start=0, tx_data=0x00, busy=0, timeout_err=0, last_owner=N_REQ-1, and the timeout counter.
REQ-031 After reset release, the first tx_start occurs no earlier than 2 cycles after the first clk edge with req_valid and tx_ready both high.
REQ-032 A packet interrupted by reset is not resumed; the requester restarts it.

Structure
REQ-033 The FSM state encoding and the default values of N_REQ and BUSY_TO live in the shared UART package.
REQ-034 Round-robin selection is one combinational sub-module, rr_pick, with inputs req and last_owner and output a one-hot winner.
REQ-035 The block instantiates no transmitter; it connects to the existing transmit path at the top level.

Verification
REQ-036 Single byte: r0 sends 0x55 with last=1 and the model returns tx_ready low 3 cycles after tx_start.
  - Required: tx_start 2 cycles after valid, tx_data=0x55, one req_ack[0], grant returns to 0, busy low after tx_ready rises.
REQ-037 Contention: r1 and r3 each present a 2-byte packet in the same cycle after reset.
  - Required: r1 is served first (search starts at 0) with bytes in order and no r3 byte interleaved; r3 follows; last_owner=3.
REQ-038 Fairness and wrap: all four requesters stream 1-byte packets continuously.
  - Required: grant order 0,1,2,3,0,1 with no requester skipped.
REQ-039 Packet stall: r2 sends byte 0xA1 (last=0), deasserts valid for 20 cycles while r0 is valid, then sends 0xA2 (last=1).
  - Required: r0 is not granted until after 0xA2 completes.
REQ-040 Timeout: the model never drops tx_ready after tx_start and BUSY_TO=15.
  - Required: timeout_err rises 15 cycles after tx_start; timeout_clr clears it; a simultaneous clear and expiry keeps it set.
REQ-041 Reset mid-packet: assert reset during WAIT_DONE of byte 1 of a 3-byte packet.
  - Required: all outputs show reset values in the same cycle; no further ack occurs for that packet.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: default sizing,
// FSM state encoding and a small one-hot decode helper.
package uart_tx_arbiter_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int BUSY_TO_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_t;

    // Index of the set bit in a one-hot vector (up to 8 requesters).
    // An all-zero input decodes to 0.
    function automatic int onehot_to_idx(input logic [7:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection: the search starts one past the previous
// owner, wraps modulo N_REQ, and takes the first requester that is valid.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_owner,
    output logic [N_REQ-1:0]         win
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk the requesters in priority order and keep only the first hit.
    always_comb begin
        win     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = IDX_W'((int'(last_owner) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                win[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte streams onto a single UART transmitter.
// A granted requester keeps the link until the byte marked last has been
// sent; bytes are handed to the transmitter with a tx_start pulse.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no owner; pick a round-robin winner when tx is ready
// ST_LOAD      | capture owner's byte and last flag, ack the requester
// ST_START     | one-cycle tx_start pulse
// ST_WAIT_BUSY | wait for tx_ready to fall (bounded by BUSY_TO)
// ST_WAIT_DONE | wait for tx_ready to rise; continue, finish or stall packet
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int BUSY_TO = BUSY_TO_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err,
    input  logic               timeout_clr
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BUSY_TO + 1);
    // The START cycle counts as the first of the BUSY_TO cycles, so the
    // counter covers the remaining BUSY_TO-1 cycles down to zero.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_TO - 2);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_win;
    logic [IDX_W-1:0] r_last_owner;
    logic [IDX_W-1:0] w_owner_idx;
    logic [7:0]       r_tx_data;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;
    logic             w_expire;
    logic             w_owner_valid;
    logic             w_arb_go;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_owner (r_last_owner),
        .win        (w_win)
    );

    assign w_owner_idx   = IDX_W'(onehot_to_idx(8'(r_grant)));
    assign w_owner_valid = |(req_valid & r_grant);
    assign w_arb_go      = tx_ready && (|req_valid);
    assign w_expire      = (r_state == ST_WAIT_BUSY) && tx_ready && (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        w_next   = r_state;
        req_ack  = '0;
        tx_start = 1'b0;
        busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_arb_go) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                req_ack = r_grant;
                w_next  = ST_START;
            end
            ST_START: begin
                tx_start = 1'b1;
                w_next   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready || w_expire) w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Packet lock: a non-final byte holds the link for the owner
                // even while its valid is low.
                if (tx_ready) begin
                    if (r_last) begin
                        w_next = ST_IDLE;
                    end else if (w_owner_valid) begin
                        w_next = ST_LOAD;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Grant, byte/last capture, round-robin pointer and busy-wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= '0;
            r_tx_data    <= 8'h00;
            r_last       <= 1'b0;
            r_last_owner <= IDX_W'(N_REQ - 1);
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_go) r_grant <= w_win;
                end
                ST_LOAD: begin
                    r_tx_data <= req_data[{w_owner_idx, 3'b000} +: 8];
                    r_last    <= req_last[w_owner_idx];
                end
                ST_START: begin
                    r_cnt <= CNT_LOAD;
                end
                ST_WAIT_BUSY: begin
                    if (tx_ready && (r_cnt != '0)) r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_WAIT_DONE: begin
                    if (tx_ready && r_last) begin
                        r_grant      <= '0;
                        r_last_owner <= w_owner_idx;
                    end
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Sticky timeout flag; an expiry in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_expire) begin
            r_timeout_err <= 1'b1;
        end else if (timeout_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign grant       = r_grant;
    assign tx_data     = r_tx_data;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters fed from per-requester
// byte queues, a simple transmitter model, and a log of every tx_start.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;
    logic           timeout_clr;

    typedef struct {
        logic [N-1:0] g;
        logic [7:0]   d;
        int           c;
    } start_t;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    start_t     starts[$];
    logic [8:0] rq[N][$];
    bit         pend[N];
    bit         hang = 1'b0;
    int         ack_cnt[N];
    int         vcyc[N];

    uart_tx_arbiter #(
        .N_REQ   (N),
        .BUSY_TO (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_clr (timeout_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic start_t st(input int k);
        start_t s;
        s.g = '0;
        s.d = '0;
        s.c = -1000;
        if (k < starts.size()) s = starts[k];
        return s;
    endfunction

    function automatic bit q_empty();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Transmitter: goes busy the edge after tx_start, idle again 3 cycles later.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start && !hang) begin
                @(posedge clk);
                #1 tx_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    // Requesters: present the queue head; drop it the cycle after its ack.
    initial begin
        logic [8:0] h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                pend[i] = req_ack[i];
                if (rq[i].size() > 0 && !reset) begin
                    h = rq[i][0];
                    if (!req_valid[i]) vcyc[i] = cyc;
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = h[7:0];
                    req_last[i]        = h[8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: log tx_start events and check every ack against the grant.
    initial begin
        start_t s;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                s.g = grant;
                s.d = tx_data;
                s.c = cyc;
                starts.push_back(s);
            end
            if (req_ack != '0) begin
                chk("ack_onehot", 32'($onehot(req_ack)), 32'd1);
                chk("ack_is_grant", 32'(req_ack), 32'(grant));
                for (int i = 0; i < N; i++) begin
                    if (req_ack[i]) ack_cnt[i]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while ((busy || !q_empty()) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            pend[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        start_t         s;
        int             base;
        int             n;
        int             e;
        logic [N-1:0]   exp_g[8];
        logic [7:0]     exp_d[8];

        reset       = 1'b1;
        timeout_clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            ack_cnt[i] = 0;
            vcyc[i]    = 0;
            pend[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_last_owner", 32'(dut.r_last_owner), 32'd3);
        reset = 1'b0;

        // Single byte from r0.
        starts.delete();
        rq[0].push_back({1'b1, 8'h55});
        wait_idle("t1_wait");
        chk("t1_nstarts", 32'(starts.size()), 32'd1);
        s = st(0);
        chk("t1_data", 32'(s.d), 32'h55);
        chk("t1_grant", 32'(s.g), 32'b0001);
        chk("t1_latency", 32'(s.c - vcyc[0]), 32'd2);
        chk("t1_acks", 32'(ack_cnt[0]), 32'd1);
        chk("t1_grant_clr", 32'(grant), 32'd0);
        chk("t1_ready_at_idle", 32'(tx_ready), 32'd1);

        // Contention between r1 and r3 straight after reset.
        do_reset();
        starts.delete();
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b1, 8'h12});
        rq[3].push_back({1'b0, 8'h31});
        rq[3].push_back({1'b1, 8'h32});
        wait_idle("t2_wait");
        exp_g[0] = 4'b0010; exp_d[0] = 8'h11;
        exp_g[1] = 4'b0010; exp_d[1] = 8'h12;
        exp_g[2] = 4'b1000; exp_d[2] = 8'h31;
        exp_g[3] = 4'b1000; exp_d[3] = 8'h32;
        chk("t2_nstarts", 32'(starts.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            s = st(j);
            chk($sformatf("t2_byte%0d", j), {20'd0, s.g, s.d}, {20'd0, exp_g[j], exp_d[j]});
        end
        chk("t2_last_owner", 32'(dut.r_last_owner), 32'd3);

        // All four requesters stream two 1-byte packets each.
        starts.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                rq[i].push_back({1'b1, 4'(i), 4'(k)});
            end
        end
        wait_idle("t3_wait");
        chk("t3_nstarts", 32'(starts.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            s = st(j);
            chk($sformatf("t3_order%0d", j), {20'd0, s.g, s.d},
                {20'd0, 4'(1 << (j % 4)), 4'(j % 4), 4'(j / 4)});
        end

        // r2 stalls mid-packet while r0 waits.
        starts.delete();
        base = ack_cnt[2];
        rq[2].push_back({1'b0, 8'hA1});
        n = 0;
        while (ack_cnt[2] == base && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ack_a1", 32'(ack_cnt[2] - base), 32'd1);
        rq[0].push_back({1'b1, 8'h0F});
        repeat (20) @(negedge clk);
        chk("t4_grant_held", 32'(grant), 32'b0100);
        chk("t4_busy_held", 32'(busy), 32'd1);
        rq[2].push_back({1'b1, 8'hA2});
        wait_idle("t4_wait");
        exp_g[0] = 4'b0100; exp_d[0] = 8'hA1;
        exp_g[1] = 4'b0100; exp_d[1] = 8'hA2;
        exp_g[2] = 4'b0001; exp_d[2] = 8'h0F;
        chk("t4_nstarts", 32'(starts.size()), 32'd3);
        for (int j = 0; j < 3; j++) begin
            s = st(j);
            chk($sformatf("t4_byte%0d", j), {20'd0, s.g, s.d}, {20'd0, exp_g[j], exp_d[j]});
        end

        // Timeout: transmitter never goes busy.
        hang = 1'b1;
        starts.delete();
        rq[1].push_back({1'b1, 8'h77});
        n = 0;
        e = 0;
        @(negedge clk);
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = cyc;
        chk("t5_err_seen", 32'(timeout_err), 32'd1);
        s = st(0);
        chk("t5_err_delay", 32'(e - s.c), 32'd15);
        repeat (3) @(negedge clk);
        chk("t5_sticky", 32'(timeout_err), 32'd1);
        timeout_clr = 1'b1;
        @(negedge clk);
        timeout_clr = 1'b0;
        chk("t5_cleared", 32'(timeout_err), 32'd0);
        rq[1].push_back({1'b1, 8'h78});
        wait_start("t5_start2");
        repeat (14) @(negedge clk);
        chk("t5_pre_expiry", 32'(timeout_err), 32'd0);
        timeout_clr = 1'b1;
        @(negedge clk);
        timeout_clr = 1'b0;
        chk("t5_set_wins", 32'(timeout_err), 32'd1);
        wait_idle("t5_wait");
        hang = 1'b0;

        // Reset during WAIT_DONE of the first byte of a 3-byte packet.
        starts.delete();
        base = ack_cnt[3];
        rq[3].push_back({1'b0, 8'hC1});
        rq[3].push_back({1'b0, 8'hC2});
        rq[3].push_back({1'b1, 8'hC3});
        wait_start("t6_start");
        repeat (3) @(negedge clk);
        chk("t6_in_wait_done", 32'(busy && !tx_ready), 32'd1);
        #2;
        reset = 1'b1;
        rq[3].delete();
        pend[3] = 1'b0;
        #1;
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_ack", 32'(req_ack), 32'd0);
        chk("t6_start", 32'(tx_start), 32'd0);
        chk("t6_data", 32'(tx_data), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_terr", 32'(timeout_err), 32'd0);
        chk("t6_last_owner", 32'(dut.r_last_owner), 32'd3);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_no_more_acks", 32'(ack_cnt[3] - base), 32'd1);
        chk("t6_no_more_starts", 32'(starts.size()), 32'd1);
        chk("t6_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
